// File: rtl/pipe_buf_pkg.sv
// Shared types for the pipeline stage buffer: buffer state encoding and RV32I stage payloads.
// Bubble constants carry a NOP instruction with all control bits cleared.
package pipe_buf_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [31:0] CURR_INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam if_id_t  IF_ID_BUBBLE  = '{pc: 32'h0, instr: CURR_INSTR_NOP};
    localparam id_ex_t  ID_EX_BUBBLE  = '{pc: 32'h0, instr: CURR_INSTR_NOP, rs1_val: 32'h0,
                                          rs2_val: 32'h0, imm: 32'h0, rd: 5'h0, alu_op: 4'h0,
                                          mem_rd: 1'b0, mem_wr: 1'b0, reg_wr: 1'b0};
    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency 1 cycle; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, optional skid entry, flush and stall counter.
// Latency 1 cycle; with SKID=1 in_ready is registered and drops only once both entries are held.
module pipe_stage_buffer
    import pipe_buf_pkg::*;
#(
    parameter int                WIDTH  = 32,
    parameter int                SKID   = 1,
    parameter logic [WIDTH-1:0]  BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    state_t           state;
    logic [WIDTH-1:0] m_dat;
    logic [WIDTH-1:0] s_dat;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state != ST_EMPTY);
    // Masking by out_valid keeps BUBBLE on the output even if stale payload remains in m_dat.
    assign out_data  = out_valid ? m_dat : BUBBLE;
    assign in_ready  = (SKID != 0) ? (state != ST_SKID) : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            m_dat <= BUBBLE;
            s_dat <= BUBBLE;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        m_dat <= in_data;
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        m_dat <= in_data;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry; single-entry ready requires out_fire.
                        if (SKID != 0) begin
                            s_dat <= in_data;
                            state <= ST_SKID;
                        end
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        m_dat <= s_dat;
                        state <= ST_FULL;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out_valid && !out_ready && !flush),
        .clr  (stall_clr),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: skid variant (CNT_W=4) and single-entry variant (CNT_W=16).
module tb_pipe_stage_buffer;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv[2], ordy[2], fl[2], clr[2], ir[2], ov[2];
    logic [31:0] id[2], od[2];
    logic [3:0]  sc1;
    logic [15:0] sc0;

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of at most cap entries plus a saturating stall count.
    logic [31:0] mq[2][2];
    int          mn[2];
    int          mcnt[2];
    int          mmax[2] = '{65535, 15};

    always #5 clk = ~clk;

    pipe_stage_buffer #(.WIDTH(32), .SKID(1), .BUBBLE(BUB), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .flush(fl[1]),
        .stall_cnt(sc1), .stall_clr(clr[1]));

    pipe_stage_buffer #(.WIDTH(32), .SKID(0), .BUBBLE(BUB), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .flush(fl[0]),
        .stall_cnt(sc0), .stall_clr(clr[0]));

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic        er;
        logic [3:0]  ec;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic i_v, input logic [31:0] d, input logic o_r,
                                input logic f, input logic c, input logic e_v,
                                input logic [31:0] e_d, input logic e_r, input logic [3:0] e_c);
        vec_t v;
        v.iv = i_v; v.d = d; v.ordy = o_r; v.fl = f; v.clr = c;
        v.ev = e_v; v.ed = e_d; v.er = e_r; v.ec = e_c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        return (k == 1) ? {28'h0, sc1} : {16'h0, sc0};
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; id[k] = 32'h0; ordy[k] = 1'b0; fl[k] = 1'b0; clr[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; mcnt[k] = 0;
        end
    endtask

    // One cycle on DUT k: compare outputs with the model, then advance the model across the edge.
    task automatic step(input int k);
        logic        ev, er, in_acc, out_acc;
        logic [31:0] ed;
        @(negedge clk);
        ev = (mn[k] > 0);
        ed = ev ? mq[k][0] : BUB;
        er = (k == 1) ? (mn[k] < 2) : ((mn[k] == 0) || ordy[k]);
        chk("out_valid", {31'h0, ov[k]}, {31'h0, ev});
        chk("out_data", od[k], ed);
        chk("in_ready", {31'h0, ir[k]}, {31'h0, er});
        chk("stall_cnt", cnt_of(k), mcnt[k]);
        in_acc  = iv[k] && er;
        out_acc = ev && ordy[k];
        if (clr[k]) mcnt[k] = 0;
        else if (ev && !ordy[k] && !fl[k] && mcnt[k] < mmax[k]) mcnt[k]++;
        if (fl[k]) begin
            mn[k] = 0;
        end else begin
            if (out_acc) begin
                mq[k][0] = mq[k][1];
                mn[k]--;
            end
            if (in_acc) begin
                mq[k][mn[k]] = id[k];
                mn[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();

        tbl[0]  = mk(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0, BUB,    1'b1, 4'd0);
        tbl[1]  = mk(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  1'b1, 4'd0);
        tbl[2]  = mk(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 4'd1);
        tbl[3]  = mk(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 4'd2);
        tbl[4]  = mk(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 4'd3);
        tbl[5]  = mk(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB,  1'b1, 4'd3);
        tbl[6]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 4'd3);
        tbl[7]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, BUB,    1'b1, 4'd3);
        tbl[8]  = mk(1'b1, 32'hE, 1'b0, 1'b0, 1'b0, 1'b0, BUB,    1'b1, 4'd3);
        tbl[9]  = mk(1'b1, 32'hF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hE,  1'b1, 4'd3);
        tbl[10] = mk(1'b1, 32'hD, 1'b0, 1'b1, 1'b0, 1'b1, 32'hE,  1'b0, 4'd4);
        tbl[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, BUB,    1'b1, 4'd4);
        tbl[12] = mk(1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, BUB,    1'b1, 4'd4);
        tbl[13] = mk(1'b1, 32'hD, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1,  1'b1, 4'd4);
        tbl[14] = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, BUB,    1'b1, 4'd4);
        tbl[15] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, BUB,    1'b1, 4'd0);

        do_reset();
        @(negedge clk);
        chk("rst_out_valid", {31'h0, ov[1]}, 32'h0);
        chk("rst_out_data", od[1], BUB);
        chk("rst_in_ready", {31'h0, ir[1]}, 32'h1);
        chk("rst_stall_cnt", cnt_of(1), 32'h0);
        chk("rst_out_data_s0", od[0], BUB);
        @(posedge clk);
        #1;

        // Backpressure, skid fill, flush in SKID and FULL, stall clear.
        for (int i = 0; i < 16; i++) begin
            iv[1] = tbl[i].iv; id[1] = tbl[i].d; ordy[1] = tbl[i].ordy;
            fl[1] = tbl[i].fl; clr[1] = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", i), {31'h0, ov[1]}, {31'h0, tbl[i].ev});
            chk($sformatf("tbl%0d_out_data", i), od[1], tbl[i].ed);
            chk($sformatf("tbl%0d_in_ready", i), {31'h0, ir[1]}, {31'h0, tbl[i].er});
            chk($sformatf("tbl%0d_stall_cnt", i), cnt_of(1), {28'h0, tbl[i].ec});
            @(posedge clk);
            #1;
        end

        // Saturation at 15 with CNT_W=4, then clear while still stalled.
        iv[1] = 1'b1; id[1] = 32'h55; ordy[1] = 1'b0; fl[1] = 1'b0; clr[1] = 1'b0;
        @(posedge clk);
        #1 iv[1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", cnt_of(1), 32'd15);
        chk("sat_held_data", od[1], 32'h55);
        clr[1] = 1'b1;
        @(posedge clk);
        #1 clr[1] = 1'b0;
        @(negedge clk);
        chk("sat_clr", cnt_of(1), 32'd0);
        @(negedge clk);
        chk("sat_after_clr", cnt_of(1), 32'd1);

        // Streaming 1..8 back-to-back with out_ready=1.
        do_reset();
        ordy[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv[1] = 1'b1; id[1] = i;
            step(1);
        end
        iv[1] = 1'b0;
        step(1);
        step(1);

        // Asynchronous reset asserted mid-cycle while FULL.
        iv[1] = 1'b1; id[1] = 32'h77; ordy[1] = 1'b0;
        @(posedge clk);
        #1 iv[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", {31'h0, ov[1]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'h0, ov[1]}, 32'h0);
        chk("mid_rst_out_data", od[1], BUB);
        chk("mid_rst_stall_cnt", cnt_of(1), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, ir[1]}, 32'h1);
        chk("post_rst_out_valid", {31'h0, ov[1]}, 32'h0);

        // Randomized traffic on the skid variant.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            iv[1] = ($urandom_range(9) < 7); id[1] = $urandom;
            ordy[1] = ($urandom_range(9) < 5);
            fl[1] = ($urandom_range(19) == 0); clr[1] = ($urandom_range(29) == 0);
            step(1);
        end

        // Single-entry variant: out_ready toggling with continuous in_valid.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iv[0] = 1'b1; id[0] = 32'h100 + i; ordy[0] = (i % 2 == 0);
            step(0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        step(0);
        step(0);
        for (int i = 0; i < 400; i++) begin
            iv[0] = ($urandom_range(9) < 7); id[0] = $urandom;
            ordy[0] = ($urandom_range(9) < 6);
            fl[0] = ($urandom_range(19) == 0); clr[0] = ($urandom_range(29) == 0);
            step(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
